// File: rtl/nrisc_mem_responder.sv
// nrisc_mem_responder: single-port 256x8 memory serving instruction fetches and data accesses with fair arbitration.
// Optional macro MEM_WRITE_PROTECT_EN rejects writes to 0x00-0x3F and pulses WrErr alongside DataAck.
module nrisc_mem_responder (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic       FetchReq,
  input  logic [7:0] pc,
  output logic [7:0] memInstr,
  output logic       InstrAck,
  input  logic       MemRead,
  input  logic       MemWrite,
  input  logic [7:0] addr,
  input  logic [7:0] dadoEscrito,
  output logic [7:0] readData,
  output logic       DataAck,
  output logic       halt,
  output logic       WrErr
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACK_D = 2'd1;
  localparam logic [1:0] ACK_I = 2'd2;
  logic [1:0] state_q, state_d;
  logic       fair_q, fair_d, wr_err_q, wr_err_d;
  logic [7:0] read_data_q, read_data_d, instr_q, instr_d;
  logic [7:0] acc_addr, rd_data;
  logic       idle, grant_d, grant_i, wr_en, prot;
  logic [7:0] mem [256];
`ifdef MEM_WRITE_PROTECT_EN
  assign prot = addr[7:6] == 2'b00;
`else
  assign prot = 1'b0;
`endif
  // The fairness flag hands the next grant to a fetch that lost to data.
  always_comb begin
    idle        = state_q == IDLE;
    grant_d     = idle & (MemRead | MemWrite) & ~(FetchReq & fair_q);
    grant_i     = idle & FetchReq & ~grant_d;
    wr_en       = grant_d & MemWrite & ~prot;
    acc_addr    = grant_i ? pc : addr;
    rd_data     = mem[acc_addr];
    state_d     = grant_d ? ACK_D : grant_i ? ACK_I : IDLE;
    fair_d      = grant_i ? 1'b0 : (grant_d & FetchReq) | fair_q;
    read_data_d = (grant_d & ~MemWrite) ? rd_data : read_data_q;
    instr_d     = grant_i ? rd_data : instr_q;
    wr_err_d    = grant_d & MemWrite & prot;
  end
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      fair_q      <= 1'b0;
      wr_err_q    <= 1'b0;
      read_data_q <= 8'h00;
      instr_q     <= 8'h00;
    end else begin
      state_q     <= state_d;
      fair_q      <= fair_d;
      wr_err_q    <= wr_err_d;
      read_data_q <= read_data_d;
      instr_q     <= instr_d;
    end
  end
  // Storage is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge Clock) begin
    if (wr_en) mem[addr] <= dadoEscrito;
  end
  assign DataAck  = state_q == ACK_D;
  assign InstrAck = state_q == ACK_I;
  assign WrErr    = wr_err_q;
  assign readData = read_data_q;
  assign memInstr = instr_q;
  assign halt     = (FetchReq & ~InstrAck) | ((MemRead | MemWrite) & ~DataAck);
endmodule

// File: tb/tb_nrisc_mem_responder.sv
// tb_nrisc_mem_responder: directed self-checking bench for nrisc_mem_responder.
module tb_nrisc_mem_responder;
  logic       Clock = 1'b0;
  logic       Reset_n, FetchReq, MemRead, MemWrite;
  logic [7:0] pc, addr, dadoEscrito;
  logic [7:0] memInstr, readData;
  logic       InstrAck, DataAck, halt, WrErr;
  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] prior;

  nrisc_mem_responder dut (
    .Clock(Clock), .Reset_n(Reset_n), .FetchReq(FetchReq), .pc(pc),
    .memInstr(memInstr), .InstrAck(InstrAck), .MemRead(MemRead),
    .MemWrite(MemWrite), .addr(addr), .dadoEscrito(dadoEscrito),
    .readData(readData), .DataAck(DataAck), .halt(halt), .WrErr(WrErr)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    Reset_n = 1'b0; FetchReq = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    pc = 8'h00; addr = 8'h00; dadoEscrito = 8'h00;
    #3;
    chk("rst_dack", DataAck, 0);
    chk("rst_iack", InstrAck, 0);
    chk("rst_rdata", readData, 8'h00);
    chk("rst_instr", memInstr, 8'h00);
    chk("rst_halt", halt, 0);
    chk("rst_wrerr", WrErr, 0);
    tick(); tick();
    Reset_n = 1'b1;
    tick();

    // write 0x5A to 0x80, then read it back
    MemWrite = 1'b1; addr = 8'h80; dadoEscrito = 8'h5A;
    #1 chk("wr_halt_pend", halt, 1);
    tick();
    chk("wr_dack", DataAck, 1);
    chk("wr_halt_ack", halt, 0);
    chk("wr_rdata_keep", readData, 8'h00);
    chk("wr_wrerr", WrErr, 0);
    MemWrite = 1'b0;
    tick();
    chk("wr_dack_drop", DataAck, 0);
    MemRead = 1'b1;
    tick();
    chk("rd_dack", DataAck, 1);
    chk("rd_data", readData, 8'h5A);
    chk("rd_halt_ack", halt, 0);
    MemRead = 1'b0;
    tick();
    chk("rd_dack_drop", DataAck, 0);
    chk("rd_data_hold", readData, 8'h5A);

    // read+write together behaves as a write
    MemRead = 1'b1; MemWrite = 1'b1; addr = 8'h20; dadoEscrito = 8'h33;
    tick();
    chk("rw_dack", DataAck, 1);
    chk("rw_rdata_keep", readData, 8'h5A);
    MemRead = 1'b0; MemWrite = 1'b0;
    tick();
    chk("rw_single_ack", DataAck, 0);
    MemRead = 1'b1;
    tick();
    chk("rw_readback", readData, 8'h33);
    MemRead = 1'b0;
    tick();

    // simultaneous fetch and read: data first, then fetch beats a new data request
    FetchReq = 1'b1; pc = 8'h20; MemRead = 1'b1; addr = 8'h80;
    tick();
    chk("arb_dack", DataAck, 1);
    chk("arb_iack0", InstrAck, 0);
    chk("arb_rdata", readData, 8'h5A);
    chk("arb_halt", halt, 1);
    MemRead = 1'b0;
    tick();
    chk("arb_idle_d", DataAck, 0);
    chk("arb_idle_i", InstrAck, 0);
    MemRead = 1'b1; addr = 8'h20;
    tick();
    chk("arb_fair_iack", InstrAck, 1);
    chk("arb_fair_dack", DataAck, 0);
    chk("arb_instr", memInstr, 8'h33);
    FetchReq = 1'b0;
    tick();
    tick();
    chk("arb_late_dack", DataAck, 1);
    chk("arb_late_rdata", readData, 8'h33);
    MemRead = 1'b0;
    tick();

    // continuous requests must alternate
    FetchReq = 1'b1; pc = 8'h80; MemRead = 1'b1; addr = 8'h20;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("alt_dack_%0d", i), DataAck, (i % 4 == 0) ? 8'h01 : 8'h00);
      chk($sformatf("alt_iack_%0d", i), InstrAck, (i % 4 == 2) ? 8'h01 : 8'h00);
    end
    chk("alt_instr", memInstr, 8'h5A);
    chk("alt_rdata", readData, 8'h33);
    FetchReq = 1'b0; MemRead = 1'b0;
    tick();

    // reset during the ack cycle
    MemRead = 1'b1; addr = 8'h80;
    tick();
    chk("rst_mid_dack_pre", DataAck, 1);
    #1 Reset_n = 1'b0;
    #1;
    chk("rst_mid_dack", DataAck, 0);
    chk("rst_mid_rdata", readData, 8'h00);
    chk("rst_mid_halt", halt, 1);
    tick();
    Reset_n = 1'b1;
    tick();
    chk("rst_reserve_dack", DataAck, 1);
    chk("rst_reserve_rdata", readData, 8'h5A);
    MemRead = 1'b0;
    tick();

    // write to the protected region
    MemRead = 1'b1; addr = 8'h10;
    tick();
    prior = readData;
    MemRead = 1'b0;
    tick();
    MemWrite = 1'b1; dadoEscrito = 8'hFF;
    tick();
    chk("wp_dack", DataAck, 1);
`ifdef MEM_WRITE_PROTECT_EN
    chk("wp_wrerr", WrErr, 1);
`else
    chk("wp_wrerr", WrErr, 0);
`endif
    MemWrite = 1'b0;
    tick();
    chk("wp_wrerr_drop", WrErr, 0);
    MemRead = 1'b1;
    tick();
`ifdef MEM_WRITE_PROTECT_EN
    chk("wp_readback", readData, prior);
`else
    chk("wp_readback", readData, 8'hFF);
`endif
    chk("wp_rd_wrerr", WrErr, 0);
    MemRead = 1'b0;
    tick();

    // top address is ordinary
    MemWrite = 1'b1; addr = 8'hFF; dadoEscrito = 8'hC3;
    tick();
    MemWrite = 1'b0;
    tick();
    FetchReq = 1'b1; pc = 8'hFF;
    tick();
    chk("ff_iack", InstrAck, 1);
    chk("ff_instr", memInstr, 8'hC3);
    chk("ff_halt", halt, 0);
    FetchReq = 1'b0;
    tick();
    chk("ff_iack_drop", InstrAck, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
